uart_tx_gen: RTL
================

Name: uart_tx_gen

Overview:
Parametrised successor of the fixed-format UART transmitter. Adds runtime-selectable data width (5..DATA_W_MAX), parity (none/even/odd) and 1 or 2 stop bits, a programmable baud divisor, and an internal TX FIFO with a valid/ready write port. Sits between the bus-side CSR logic and the pad; the CSR block drives cfg_* and pushes bytes, the FSM serialises them onto tx.

Parameters:
DATA_W_MAX, 9, widest supported data field and width of wr_data (min 8)
FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2
DIV_W, 16, width of baud divisor

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_en  in  1  allows new frames to start
cfg_div  in  DIV_W  clocks per bit minus 1 (0 = 1 clk/bit)
cfg_data_bits  in  4  data bits per frame, valid 5..DATA_W_MAX
cfg_parity  in  2  0 none, 1 even, 2 odd, 3 treated as none
cfg_stop2  in  1  1 = two stop bits
wr_valid  in  1  write request
wr_data  in  DATA_W_MAX  frame data, LSB-aligned
wr_ready  out  1  FIFO can accept (= not full)
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
tx  out  1  serial line, registered
busy  out  1  FSM not in IDLE
data_sent  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, immediate): tx=1, busy=0, data_sent=0, FIFO empty, fifo_count=0, wr_ready=1, FSM=IDLE, counters cleared.
- Write accepted on a rising edge with wr_valid&&wr_ready. wr_ready=0 when full, regardless of a same-cycle pop. Writes with wr_ready=0 are ignored; there is no overflow state.
- Simultaneous push and pop on a non-full FIFO: count unchanged, ordering preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when tx_en=1 and FIFO non-empty. On that edge: pop the head, latch data/cfg_data_bits/cfg_parity/cfg_stop2/cfg_div into frame registers, and drive tx=0.
- cfg changes mid-frame have no effect until the next frame start.
- Bit timing: a divisor counter reloads at each bit start; each bit lasts exactly latched_div+1 clocks.
- START (1 bit, tx=0) -> DATA.
- DATA: N bits, LSB first; N = latched cfg_data_bits. Values <5 or >DATA_W_MAX are treated as 8. Bits above N are ignored. Exit to PARITY if parity is enabled, else STOP.
- PARITY (1 bit): even = XOR of the N data bits; odd = its inverse.
- STOP: 1 or 2 bits, tx=1.
- Frame length in clocks = (div+1)*(1+N+P+S).
- End of last stop bit: data_sent pulses for 1 clk.
  - If tx_en=1 and the FIFO is non-empty, the next START begins on that same edge (no idle gap; busy stays 1).
  - Otherwise -> IDLE, busy=0.
- Latency: write sampled at edge k into an empty FIFO with FSM idle and tx_en=1 -> tx low after edge k+1.
- tx_en deasserted mid-frame: current frame completes normally; no new frame starts.
- Reset mid-frame: tx returns to 1 immediately; FIFO contents are discarded; no data_sent pulse.
- busy = (state != IDLE), registered with the state.

Decomposition:
- uart_gen_pkg holds:
  - tx_state_e enum {IDLE, START, DATA, PARITY, STOP}
  - parity_e enum {PAR_NONE, PAR_EVEN, PAR_ODD}
  - DEFAULT_DATA_BITS=8, MIN_DATA_BITS=5
  - function frame_parity(data, nbits, mode)
- Sub-module uart_tx_fifo (DEPTH, WIDTH parameters):
  - sync FIFO with push/pop, full/empty, count
  - async active-high reset
  - FSM, divisor counter, bit counter and shifter remain in uart_tx_gen.

Test Plan:
- div=3, 8N1, write 0xA5 -> tx: 0,1,0,1,0,0,1,0,1,1, each held 4 clk; data_sent once, 40 clk after tx falls; busy 0 afterwards.
- div=0, 7 bits, even parity, 2 stop, write 0x53 -> bits 0,1,1,0,0,1,0,1,0,1,1 (parity 0), 11 clk frame.
- Odd parity, 9 bits, write 0x1FF -> parity bit 0 (nine ones). cfg_data_bits=12 -> frame uses 8 bits of 0x1FF (0xFF).
- FIFO_DEPTH=8, tx_en=0, write 9 words -> wr_ready low after 8th, 9th ignored, fifo_count=8. Set tx_en=1 -> 8 frames back-to-back with no idle gap, 8 data_sent pulses, order preserved.
- Mid-frame: change cfg_div and cfg_parity during DATA -> current frame unchanged, next frame uses new cfg. Drop tx_en mid-frame -> frame completes, FIFO holds remaining words.
- Assert rst during DATA -> tx=1 in the same cycle, busy=0, fifo_count=0, no data_sent pulse; a post-reset write transmits correctly.

Source files
------------

// File: rtl/uart_gen_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
//   tx_state_e    : serialiser states
//   parity_e      : decoded parity mode
//   frame_parity(): parity bit over the low nbits of a data word
package uart_gen_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  localparam logic [3:0] DEFAULT_DATA_BITS = 4'd8;
  localparam logic [3:0] MIN_DATA_BITS     = 4'd5;

  // Working width for parity evaluation; wide enough for any 4-bit bit count.
  localparam int PAR_W = 16;

  // Code 3 is reserved and behaves like "no parity".
  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic frame_parity(input logic [PAR_W-1:0] data,
                                        input logic [3:0] nbits,
                                        input parity_e mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PAR_W; i++) begin
      if (i < int'(nbits)) p ^= data[i];
    end
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Write port of the transmitter FIFO (CSR side is master, transmitter is slave).
//   wr_valid   : write request
//   wr_data    : frame data, LSB-aligned
//   wr_ready   : FIFO not full
//   fifo_count : current FIFO occupancy
interface uart_tx_gen_if #(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 8
) ();

  logic                          wr_valid;
  logic [DATA_W_MAX-1:0]         wr_data;
  logic                          wr_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (output wr_valid, wr_data, input wr_ready, fifo_count);
  modport slave  (input wr_valid, wr_data, output wr_ready, fifo_count);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding words waiting to be serialised.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write request (ignored when full)
//   push_data : word to write
//   pop       : remove head (ignored when empty)
//   head      : oldest word
//   full/empty/count : occupancy status
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full blocks writes even if a pop happens on the same edge.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// Configurable UART transmitter with internal TX FIFO.
//   clk, rst       : clock, asynchronous active-high reset
//   tx_en          : allows new frames to start
//   cfg_div        : clocks per bit minus 1
//   cfg_data_bits  : data bits per frame (5..DATA_W_MAX, otherwise 8)
//   cfg_parity     : 0 none, 1 even, 2 odd, 3 none
//   cfg_stop2      : two stop bits when set
//   wr             : FIFO write port (valid/ready, data, occupancy)
//   tx             : registered serial line
//   busy           : serialiser not idle
//   data_sent      : one-clock pulse at the end of each frame
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a queued word
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (tx=1)
module uart_tx_gen
  import uart_gen_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  uart_tx_gen_if.slave      wr,
  output logic              tx,
  output logic              busy,
  output logic              data_sent
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W_MAX);

  logic [DATA_W_MAX-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W_MAX)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (wr.fifo_count)
  );

  assign wr.wr_ready = !fifo_full;

  tx_state_e             state;
  logic [DIV_W-1:0]      f_div;
  logic [DIV_W-1:0]      div_cnt;
  logic [3:0]            f_bits;
  logic [3:0]            bit_cnt;
  parity_e               f_par;
  logic                  f_stop2;
  logic                  f_par_bit;
  logic [DATA_W_MAX-1:0] shreg;

  logic [3:0] start_bits;
  parity_e    start_par;
  logic       bit_end;
  logic       frame_done;

  assign start_bits = (cfg_data_bits < MIN_DATA_BITS || cfg_data_bits > MAX_BITS)
                      ? DEFAULT_DATA_BITS : cfg_data_bits;
  assign start_par  = decode_parity(cfg_parity);

  // Divisor counter counts down to zero; zero marks the last clock of a bit.
  assign bit_end    = (div_cnt == '0);
  assign frame_done = (state == STOP) && bit_end && (bit_cnt == '0);
  // A new frame may start from idle or directly on the last stop-bit edge.
  assign pop        = tx_en && !fifo_empty && (state == IDLE || frame_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      data_sent <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      f_div     <= '0;
      f_bits    <= DEFAULT_DATA_BITS;
      f_par     <= PAR_NONE;
      f_stop2   <= 1'b0;
      f_par_bit <= 1'b0;
    end else begin
      data_sent <= frame_done;
      if (pop) begin
        state     <= START;
        busy      <= 1'b1;
        tx        <= 1'b0;
        shreg     <= head;
        f_bits    <= start_bits;
        f_par     <= start_par;
        f_stop2   <= cfg_stop2;
        f_div     <= cfg_div;
        div_cnt   <= cfg_div;
        f_par_bit <= frame_parity(PAR_W'(head), start_bits, start_par);
      end else if (state != IDLE && !bit_end) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end else begin
        div_cnt <= f_div;
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= f_bits - 4'd1;
          end
          DATA: begin
            if (bit_cnt != '0) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt - 4'd1;
            end else if (f_par != PAR_NONE) begin
              state <= PARITY;
              tx    <= f_par_bit;
            end else begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_cnt <= {3'b000, f_stop2};
            end
          end
          PARITY: begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= {3'b000, f_stop2};
          end
          STOP: begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 4'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
